// File: rtl/mips_cpu_pkg.sv
// Shared CPU definitions: mult/div op encoding driven by aluControl,
// the mult/div sequencer states, and datapath sizing constants.
package mips_cpu_pkg;

    localparam int WORD_W   = 32;
    localparam int MD_ITERS = 32;
    localparam int MD_CNT_W = $clog2(MD_ITERS);

    // toMult encoding produced by aluControl
    typedef enum logic [2:0] {
        OP_DIVU  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_MULT  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MFHI  = 3'b110,
        OP_MFLO  = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } md_state_e;

    // Magnitude of v; only negated when the op is signed and v is negative.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [WORD_W-1:0] md_mag(input logic [WORD_W-1:0] v,
                                                 input logic               sgn);
        return (sgn && v[WORD_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mips_cpu_multdiv.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per cycle on a
// shared 33-bit add/subtract, sign fix-up in FIN, plus MTHI/MTLO/MFHI/MFLO.
import mips_cpu_pkg::*;

module mips_cpu_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    md_state_e             state, state_next;
    md_op_e                op_e;

    // acc: running HI (partial product high / remainder)
    // wrk: running LO (multiplier shifting out / dividend in, quotient out)
    logic [WIDTH-1:0]      acc, wrk, opnd;
    logic [MD_CNT_W-1:0]   cnt;
    logic                  is_div, neg_lo, neg_hi;

    logic                  accept, signed_op, div_op;
    logic [WIDTH:0]        add_a, add_b;
    logic [WIDTH+1:0]      add_out;
    logic                  borrow;

    logic [2*WIDTH-1:0]    prod, prod_fix;
    logic [WIDTH-1:0]      hi_fin, lo_fin;

    assign op_e      = md_op_e'(op);
    assign signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
    assign div_op    = (op_e == OP_DIV)  || (op_e == OP_DIVU);
    assign accept    = (state == IDLE) && start && !op[2];
    assign busy      = (state != IDLE);

    // Shared adder: subtract divisor from shifted remainder, or add multiplicand
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (is_div) begin
            add_a   = {acc, wrk[WIDTH-1]};
            add_b   = {1'b0, opnd};
            add_out = {1'b0, add_a} - {1'b0, add_b};
        end else begin
            add_a   = {1'b0, acc};
            add_b   = wrk[0] ? {1'b0, opnd} : '0;
            add_out = {1'b0, add_a} + {1'b0, add_b};
        end
        borrow = add_out[WIDTH+1];
    end

    // Sign correction of the magnitude result, applied while in FIN
    always_comb begin
        prod     = {acc, wrk};
        prod_fix = neg_lo ? (~prod + 1'b1) : prod;
        if (is_div) begin
            lo_fin = neg_lo ? (~wrk + 1'b1) : wrk;
            hi_fin = neg_hi ? (~acc + 1'b1) : acc;
        end else begin
            lo_fin = prod_fix[WIDTH-1:0];
            hi_fin = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state: 32 RUN cycles, one FIN cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (cnt == '0) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Iteration datapath: operand latch on accept, one radix-2 step per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            wrk    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else if (accept) begin
            acc    <= '0;
            cnt    <= MD_CNT_W'(MD_ITERS - 1);
            is_div <= div_op;
            if (div_op && (b == '0)) begin
                // Zero divisor: raw dividend shifts into the remainder and
                // every step "succeeds", giving HI=a, LO=all ones unchanged.
                wrk    <= a;
                opnd   <= '0;
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
            end else begin
                wrk    <= md_mag(a, signed_op);
                opnd   <= md_mag(b, signed_op);
                neg_lo <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi <= signed_op && div_op && a[WIDTH-1];
            end
        end else if (state == RUN) begin
            if (cnt != '0) cnt <= cnt - MD_CNT_W'(1);
            if (is_div) begin
                if (!borrow) begin
                    acc <= add_out[WIDTH-1:0];
                    wrk <= {wrk[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= add_a[WIDTH-1:0];
                    wrk <= {wrk[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc <= add_out[WIDTH:1];
                wrk <= {add_out[0], wrk[WIDTH-1:1]};
            end
        end
    end

    // Architectural HI/LO: written only leaving FIN or by MTHI/MTLO in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIN) begin
            hi <= hi_fin;
            lo <= lo_fin;
        end else if ((state == IDLE) && start) begin
            if (op_e == OP_MTHI) hi <= a;
            if (op_e == OP_MTLO) lo <= a;
        end
    end

    // MFHI/MFLO read port
    always_comb begin
        result = '0;
        if (op_e == OP_MFHI) result = hi;
        else if (op_e == OP_MFLO) result = lo;
    end

endmodule

// File: tb/tb_mips_cpu_multdiv.sv
// Scoreboard bench for mips_cpu_multdiv: expected {HI,LO} pushed on issue,
// popped and compared when the unit drops busy.
import mips_cpu_pkg::*;

module tb_mips_cpu_multdiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0, b = '0;
    logic        busy;
    logic [31:0] hi, lo, result;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    logic [31:0] m_hi = '0, m_lo = '0;

    mips_cpu_multdiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural reference for {HI,LO}
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint p;
        int     sx, sy, q, r;
        case (o)
            OP_MULTU: return {32'b0, x} * {32'b0, y};
            OP_MULT: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return p;
            end
            OP_DIVU: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            OP_DIV: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                sx = $signed(x);
                sy = $signed(y);
                q  = sx / sy;
                r  = sx % sy;
                return {r, q};
            end
            default: return {m_hi, m_lo};
        endcase
    endfunction

    // Issue a mult/div; optionally fire an MTLO at busy cycle inj
    task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, input int inj, input string tag);
        int          cyc;
        logic        stable;
        logic [63:0] e;
        sb.push_back(exp);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = OP_MFLO;
        cyc = 0;
        stable = 1'b1;
        while (busy && cyc < 100) begin
            if (cyc == inj) begin
                start = 1'b1; op = OP_MTLO; a = 32'h55;
            end
            @(posedge clk); #1;
            start = 1'b0; op = OP_MFLO;
            cyc++;
            if (busy && (hi !== m_hi || lo !== m_lo)) stable = 1'b0;
        end
        chk({tag, ".cycles"}, 64'(cyc), 64'd33);
        chk({tag, ".stable"}, 64'(stable), 64'd1);
        e = sb.pop_front();
        chk(tag, {hi, lo}, e);
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    // MTHI/MTLO: single edge, no busy
    task automatic run_mt(input logic [2:0] o, input logic [31:0] x,
                          input logic [63:0] exp, input string tag);
        logic [63:0] e;
        sb.push_back(exp);
        start = 1'b1; op = o; a = x;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        e = sb.pop_front();
        chk(tag, {hi, lo}, e);
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    initial begin
        logic [31:0] rx, ry;
        logic [2:0]  ro;

        // reset state
        op = OP_MFHI;
        #12;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.hilo", {hi, lo}, 64'd0);
        chk("rst.result", 64'(result), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed vectors
        run_md(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, -1, "multu_max");
        run_md(OP_MULT,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, -1, "mult_neg");
        run_md(OP_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, -1, "div_neg");
        run_md(OP_DIVU,  32'd7,        32'd0,        64'h00000007_FFFFFFFF, -1, "divu_zero");
        run_md(OP_DIV,   32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_FFFFFFFF, -1, "div_zero");
        run_md(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, -1, "div_ovf");
        run_md(OP_DIV,   32'd100,      32'hFFFFFFF9, 64'h00000002_FFFFFFF2, -1, "div_negdvs");

        // MTLO during busy is ignored; product low word wins
        run_md(OP_MULT, 32'd1000, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFF830, 5, "mult_mtlo_ign");

        // random mult/div against the reference
        for (int i = 0; i < 8; i++) begin
            ro = 3'(i % 4);
            rx = $urandom;
            ry = (i == 6) ? 32'd3 : $urandom;
            run_md(ro, rx, ry, model(ro, rx, ry), -1, $sformatf("rand%0d", i));
        end

        // start=0 with op=DIVU encoding does nothing
        start = 1'b0; op = OP_DIVU; a = 32'd5; b = 32'd3;
        @(posedge clk); #1;
        chk("nostart.busy", 64'(busy), 64'd0);
        chk("nostart.hilo", {hi, lo}, {m_hi, m_lo});

        // async reset in the middle of RUN
        start = 1'b1; op = OP_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.hilo", {hi, lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_mt(OP_MTLO, 32'h9, 64'h00000000_00000009, "arst.mtlo");

        // MTHI then MFHI/MFLO reads
        run_mt(OP_MTHI, 32'h1234, {32'h1234, m_lo}, "mthi");
        op = OP_MFHI;
        #1 chk("mfhi", 64'(result), 64'h1234);
        op = OP_MFLO;
        #1 chk("mflo", 64'(result), 64'h9);
        op = OP_MULT;
        #1 chk("result.other", 64'(result), 64'd0);
        @(posedge clk); #1;
        chk("mf.busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
